// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and fetch types, used by the fetch stage,
// the decoder and the PC logic.
package riscv_pkg;

  // Instruction width and the PC step between sequential instruction words.
  localparam int unsigned ILEN      = 32;
  localparam logic [31:0] WORD_STEP = 32'd4;

  // Default reset vector for the core.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [ILEN-1:0] word_t;

  // One prefetch queue entry: an instruction word and the address it came from.
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  // Clear the byte-offset bits of an address to get a word address.
  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: the instruction-memory request/response channel
// and the instruction handshake toward the decoder. The master side is the
// fetch stage; the slave side is the memory plus decoder environment.
interface instr_fetch_if;
  import riscv_pkg::*;

  // Instruction-memory channel.
  logic  imem_req;
  word_t imem_addr;
  logic  imem_gnt;
  logic  imem_rvalid;
  word_t imem_rdata;

  // Decoder channel.
  logic  instr_valid;
  logic  instr_ready;
  word_t instr;
  word_t instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: small {pc, instr} prefetch queue with synchronous flush.
// Flush wins over push, and a pop is ignored during a flush. A push into a
// full queue is accepted when a pop happens in the same cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  entries_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Accept/qualify push and pop, then compute next pointers and occupancy.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
    pop_ok   = pop && (count_q != '0) && !flush;
    push_ok  = push && !flush && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately not reset; count_q alone says which entries are live.
    if (push_ok) entries_q[wr_ptr_q] <= push_data;
  end

  assign head  = entries_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RISC-V instruction fetch stage. Keeps the fetch PC, issues
// in-order word requests to instruction memory under a queue-space credit,
// buffers returned words in fetch_fifo and hands {instr, pc} to the decoder.
// A redirect flushes the queue and drops responses still in flight.
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds the fetch_fault output
// and stops fetching on a misaligned redirect target; without it the low
// two bits of the redirect target are cleared.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter word_t       RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  instr_fetch_if.master        bus,
  input  logic                 redirect_valid,
  input  word_t                redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                 fetch_fault
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  word_t         fpc_q, fpc_d;
  word_t         rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] osd_q, osd_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [SW-1:0] credit_used;
  logic [CW-1:0] fifo_count;
  logic          fifo_valid;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic          imem_req;
  logic          fire;
  logic          rsp_ok;
  logic          rsp_push;
  logic          pop_req;
  logic          fault_active;
  word_t         redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic redirect_misaligned;

  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = |redirect_pc[1:0];

  // Fault is set by a misaligned redirect and cleared by an aligned one.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = redirect_misaligned;
  end

  // Fault flag register.
  always_ff @(posedge clock) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign fault_active = fault_q;
  assign fetch_fault  = fault_q;
`else
  assign redirect_target = word_align(redirect_pc);
  assign fault_active    = 1'b0;
`endif

  // Request credit, response accounting and next-state for PC/counters.
  // The next response that is not dropped always belongs to the oldest live
  // request, and live requests are sequential from the last redirect target,
  // so rsp_pc_q tracks the PC to attach to each pushed word.
  always_comb begin
    pop_req     = bus.instr_valid && bus.instr_ready;
    // A same-cycle pop frees a slot before any response to this grant can return.
    credit_used = SW'(osd_q) + SW'(fifo_count) - SW'(pop_req);
    imem_req    = reset_n && (credit_used < SW'(FQ_DEPTH)) && !redirect_valid && !fault_active;
    fire        = imem_req && bus.imem_gnt;
    // Responses with nothing outstanding (e.g. for pre-reset requests) are ignored.
    rsp_ok      = bus.imem_rvalid && (osd_q != '0);
    rsp_push    = rsp_ok && (drop_q == '0) && !redirect_valid;
    osd_d       = osd_q + CW'(fire) - CW'(rsp_ok);
    fpc_d       = fpc_q;
    drop_d      = drop_q;
    rsp_pc_d    = rsp_pc_q;
    if (redirect_valid) begin
      fpc_d    = redirect_target;
      drop_d   = osd_d;
      rsp_pc_d = redirect_target;
    end else begin
      if (fire)                      fpc_d    = fpc_q + WORD_STEP;
      if (rsp_ok && drop_q != '0)    drop_d   = drop_q - CW'(1);
      if (rsp_push)                  rsp_pc_d = rsp_pc_q + WORD_STEP;
    end
  end

  // Fetch PC, response PC and outstanding/drop counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fpc_q    <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      osd_q    <= '0;
      drop_q   <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rsp_pc_q <= rsp_pc_d;
      osd_q    <= osd_d;
      drop_q   <= drop_d;
    end
  end

  assign push_entry = '{pc: rsp_pc_q, instr: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data (push_entry),
    .pop       (pop_req),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = fpc_q;
  assign bus.instr_valid = fifo_valid;
  assign bus.instr       = fifo_valid ? fifo_head.instr : '0;
  assign bus.instr_pc    = fifo_valid ? fifo_head.pc : RESET_PC;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order memory model and a
// scoreboard of expected {pc, instr} pairs pushed at grant, popped at the
// decoder handshake.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (RST_PC),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

  pend_t       pending[$];
  exp_t        exp_q[$];
  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0, n_grant = 0, n_pop = 0;
  int          lat_v = 1;
  logic        gnt_v = 1'b1, ready_v = 1'b1, rst_v = 1'b0, redir_v = 1'b0;
  logic [31:0] redir_pc_v = '0;
  logic [31:0] exp_addr = RST_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs after the edge, then score at the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    cyc++;
    #1;
    reset_n         = rst_v;
    redirect_valid  = redir_v;
    redirect_pc     = redir_pc_v;
    bus.instr_ready = ready_v;
    bus.imem_gnt    = gnt_v;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    @(negedge clock);
    if (!reset_n) begin
      exp_q.delete();
      exp_addr = RST_PC;
    end else begin
      if (bus.imem_req && bus.imem_gnt) begin
        check("grant_addr", bus.imem_addr, exp_addr);
        pending.push_back('{addr: bus.imem_addr, due: cyc + lat_v});
        exp_q.push_back('{pc: exp_addr, ins: mem_word(exp_addr)});
        exp_addr += 32'd4;
        n_grant++;
      end
      if (bus.instr_valid && bus.instr_ready && !redirect_valid) begin
        check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pop_instr", bus.instr, e.ins);
          check("pop_pc", bus.instr_pc, e.pc);
          n_pop++;
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_addr = redirect_pc;
`else
        exp_addr = redirect_pc & ~32'h3;
`endif
      end
    end
  endtask

  initial begin
    int          p0, g0;
    logic [31:0] hold_addr;

    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;

    // Reset values.
    rst_v = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", bus.imem_addr, RST_PC);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_pc", bus.instr_pc, RST_PC);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_fault", 32'(fetch_fault), 32'd0);
`endif

    // First fetches: 0x0, 0x4, 0x8 on consecutive cycles, first word out two cycles later.
    rst_v = 1'b1;
    tick();
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, 32'h0);
    tick();
    check("addr_c1", bus.imem_addr, 32'h4);
    tick();
    check("addr_c2", bus.imem_addr, 32'h8);
    check("first_valid", 32'(bus.instr_valid), 32'd1);
    check("first_pc", bus.instr_pc, 32'h0);

    // Steady state: one instruction per cycle.
    p0 = n_pop;
    repeat (8) tick();
    check("throughput", n_pop - p0, 32'd8);

    // Reset mid-operation.
    rst_v = 1'b0;
    tick();
    check("midrst_req", 32'(bus.imem_req), 32'd0);
    tick();
    check("midrst_valid", 32'(bus.instr_valid), 32'd0);
    check("midrst_pc", bus.instr_pc, RST_PC);
    check("midrst_addr", bus.imem_addr, RST_PC);

    // Decoder stalled: exactly FQ_DEPTH grants, then requests stop.
    ready_v = 1'b0;
    rst_v   = 1'b1;
    g0      = n_grant;
    repeat (6) tick();
    check("stall_grants", n_grant - g0, 32'd2);
    check("stall_req", 32'(bus.imem_req), 32'd0);
    check("stall_valid", 32'(bus.instr_valid), 32'd1);
    ready_v = 1'b1;
    repeat (6) tick();

    // Redirect with two requests outstanding (3-cycle memory).
    lat_v = 3;
    for (int i = 0; i < 20 && pending.size() != 2; i++) tick();
    check("two_outstanding", pending.size(), 32'd2);
    redir_v    = 1'b1;
    redir_pc_v = 32'h0000_0100;
    tick();
    redir_v = 1'b0;
    tick();
    check("redir_addr", bus.imem_addr, 32'h0000_0100);
    check("redir_valid_low", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 20 && !bus.instr_valid; i++) tick();
    check("redir_first_pc", bus.instr_pc, 32'h0000_0100);

    // Redirect colliding with a response and a pop.
    lat_v = 1;
    repeat (8) tick();
    redir_v    = 1'b1;
    redir_pc_v = 32'h0000_0040;
    tick();
    check("collide_valid", 32'(bus.instr_valid), 32'd1);
    redir_v = 1'b0;
    tick();
    check("collide_next_valid", 32'(bus.instr_valid), 32'd0);
    check("collide_next_req", 32'(bus.imem_req), 32'd1);
    check("collide_next_addr", bus.imem_addr, 32'h0000_0040);

    // Grant withheld: request and address hold.
    repeat (4) tick();
    gnt_v = 1'b0;
    tick();
    hold_addr = bus.imem_addr;
    check("hold_req0", 32'(bus.imem_req), 32'd1);
    repeat (5) begin
      tick();
      check("hold_req", 32'(bus.imem_req), 32'd1);
      check("hold_addr", bus.imem_addr, hold_addr);
    end
    gnt_v = 1'b1;

    // Fetch PC wraps past the top of the address space.
    redir_v    = 1'b1;
    redir_pc_v = 32'hFFFF_FFFC;
    tick();
    redir_v = 1'b0;
    tick();
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr1", bus.imem_addr, 32'h0000_0000);
    repeat (4) tick();

    // Misaligned redirect target.
    redir_v    = 1'b1;
    redir_pc_v = 32'h0000_0102;
    tick();
    redir_v = 1'b0;
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    check("fault_set", 32'(fetch_fault), 32'd1);
    check("fault_req", 32'(bus.imem_req), 32'd0);
    repeat (4) tick();
    check("fault_hold", 32'(fetch_fault), 32'd1);
    check("fault_req_hold", 32'(bus.imem_req), 32'd0);
    check("fault_valid", 32'(bus.instr_valid), 32'd0);
    redir_v    = 1'b1;
    redir_pc_v = 32'h0000_0200;
    tick();
    redir_v = 1'b0;
    tick();
    check("fault_clear", 32'(fetch_fault), 32'd0);
    check("resume_req", 32'(bus.imem_req), 32'd1);
    check("resume_addr", bus.imem_addr, 32'h0000_0200);
`else
    check("align_addr", bus.imem_addr, 32'h0000_0100);
    check("align_req", 32'(bus.imem_req), 32'd1);
`endif
    repeat (4) tick();

    // Drain: every expected word must have come out.
    gnt_v = 1'b0;
    for (int i = 0; i < 30 && (pending.size() != 0 || bus.instr_valid); i++) tick();
    check("drain_valid", 32'(bus.instr_valid), 32'd0);
    check("drain_sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
